// File: rtl/nibbler_pkg.sv
// Shared Nibbler constants: button nibble width and debounce lengths for
// simulation and for the board, plus the debounce counter width helper.
package nibbler_pkg;

  localparam int NIB_WIDTH          = 4;
  localparam int NIB_DEBOUNCE_SIM   = 4;
  localparam int NIB_BOARD_CLK_HZ   = 50_000_000;
  // 1 ms of consecutive samples at the board clock.
  localparam int NIB_DEBOUNCE_BOARD = NIB_BOARD_CLK_HZ / 1000;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pushbutton_conditioner_debounce_bit.sv
// One button: 2-FF synchroniser, consecutive-sample debounce counter,
// registered press pulse and a sticky press latch cleared by ack.
module debounce_bit
  import nibbler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = NIB_DEBOUNCE_SIM
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic ack,
  output logic level,
  output logic pulse,
  output logic latched
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          latched_q, latched_d;
  logic          rise;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    rise     = 1'b0;
    // Any sample matching stable leaves cnt_d at zero: glitch rejection.
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        rise     = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d   = rise;
    // A press accepted on the same edge as ack wins.
    latched_d = rise | (latched_q & ~ack);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      latched_q <= latched_d;
    end
  end

  assign level   = stable_q;
  assign pulse   = pulse_q;
  assign latched = latched_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions the raw Nibbler pushbuttons for the uP core: one independent
// debounce_bit per button, with ack fanned out to every bit.
module pushbutton_conditioner
  import nibbler_pkg::*;
#(
  parameter int WIDTH           = NIB_WIDTH,
  parameter int DEBOUNCE_CYCLES = NIB_DEBOUNCE_SIM
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
  input  logic             ack,
  output logic [WIDTH-1:0] pushbuttons,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] press_latched
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock   (clock),
      .reset   (reset),
      .raw     (buttons_raw[i]),
      .ack     (ack),
      .level   (pushbuttons[i]),
      .pulse   (press_pulse[i]),
      .latched (press_latched[i])
    );
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner: directed scenarios then random button
// activity, compared every cycle against a sample-history reference model.
module tb_pushbutton_conditioner;

  localparam int W = 4;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] buttons_raw = '0;
  logic         ack = 1'b0;
  logic [W-1:0] pushbuttons, press_pulse, press_latched;

  int n_cmp = 0;
  int n_bad = 0;

  pushbutton_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .buttons_raw  (buttons_raw),
    .ack          (ack),
    .pushbuttons  (pushbuttons),
    .press_pulse  (press_pulse),
    .press_latched(press_latched)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw history gives the synchronised sample seen at each
  // edge (two edges old); a level is accepted once the last D samples all
  // disagree with the current debounced level.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] samp_hist[$];
  logic [W-1:0] m_level, m_pulse, m_latched;

  task automatic model_reset();
    raw_hist.delete();
    samp_hist.delete();
    m_level   = '0;
    m_pulse   = '0;
    m_latched = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw, input logic a);
    logic [W-1:0] s2, rise;
    int n;
    n  = raw_hist.size();
    s2 = (n >= 2) ? raw_hist[n-2] : '0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 8) void'(raw_hist.pop_front());
    samp_hist.push_back(s2);
    if (samp_hist.size() > D + 4) void'(samp_hist.pop_front());
    rise = '0;
    for (int b = 0; b < W; b++) begin
      if (samp_hist.size() >= D) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (samp_hist[samp_hist.size()-1-k][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          rise[b]    = m_level[b];
        end
      end
    end
    m_pulse   = rise;
    m_latched = rise | (m_latched & ~{W{a}});
  endtask

  task automatic check_all(input string tag);
    check({tag, "_level"},   pushbuttons,   m_level);
    check({tag, "_pulse"},   press_pulse,   m_pulse);
    check({tag, "_latched"}, press_latched, m_latched);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset) model_edge(buttons_raw, ack);
    @(negedge clock);
    check_all("cyc");
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    buttons_raw = raw;
    repeat (n) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Asynchronous reset pulse issued mid low-phase, released at a falling edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("rst");
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int hold_cnt[W];
    logic [W-1:0] r;

    // Reset values with all buttons held, then release.
    buttons_raw = 4'b1111;
    model_reset();
    #3 check_all("rst_hold");
    @(negedge clock);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("rst_rel_before", pushbuttons, 4'b0000);
    tick();
    check("rst_rel_level", pushbuttons, 4'b1111);
    check("rst_rel_pulse", press_pulse, 4'b1111);
    hold(4'b1111, 2);
    pulse_ack();
    hold(4'b0000, 8);

    // Clean press, ack, then add bit 3.
    hold(4'b0110, 8);
    check("press_latched", press_latched, 4'b0110);
    pulse_ack();
    check("press_ack", press_latched, 4'b0000);
    hold(4'b1110, 8);

    // Glitch rejection then a real press on bit 0.
    hold(4'b0000, 8);
    hold(4'b0001, 3);
    hold(4'b0000, 1);
    hold(4'b0001, 3);
    hold(4'b0000, 8);
    check("glitch_level", pushbuttons, 4'b0000);
    hold(4'b0001, 6);
    hold(4'b0000, 8);
    pulse_ack();

    // Release produces no pulse and keeps the latch.
    hold(4'b0110, 8);
    hold(4'b0000, 8);
    check("release_latched", press_latched, 4'b0110);
    pulse_ack();

    // Ack collides with bit 2 acceptance while bit 1 is latched.
    hold(4'b0010, 8);
    hold(4'b0110, 5);
    pulse_ack();
    check("ack_collide", press_latched, 4'b0100);
    pulse_ack();
    check("ack_after", press_latched, 4'b0000);
    hold(4'b0000, 8);

    // Reset in the middle of qualification.
    buttons_raw = 4'b1111;
    repeat (3) tick();
    async_reset();
    hold(4'b1111, 5);
    check("midrst_before", pushbuttons, 4'b0000);
    tick();
    check("midrst_level", pushbuttons, 4'b1111);
    hold(4'b0000, 8);

    // Random per-bit hold lengths around the acceptance threshold.
    for (int b = 0; b < W; b++) hold_cnt[b] = 0;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++) begin
        if (hold_cnt[b] == 0) begin
          r[b]        = $urandom_range(0, 1);
          hold_cnt[b] = $urandom_range(1, 9);
        end
        hold_cnt[b]--;
      end
      buttons_raw = r;
      ack = ($urandom_range(0, 7) == 0);
      tick();
      ack = 1'b0;
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pushbutton_conditioner.md
# pushbutton_conditioner

Conditions the four raw Nibbler pushbutton inputs before they reach the `uP` core's `pushbuttons` port. It synchronises each button to `clock`, debounces it with a per-bit consecutive-sample counter, and presents three things: a clean level, a one-cycle press pulse, and a sticky press latch that software clears. It sits directly upstream of `uP`, between the board pins and the processor input port.

## Interface
- `WIDTH`, 4, number of buttons; matches the Nibbler input nibble.
- `DEBOUNCE_CYCLES`, 4, consecutive differing synchronised samples required to accept a change; legal range 1..65535.
- `clock  in  1`: single system clock, rising edge.
- `reset  in  1`: asynchronous, active-low; all state cleared while low.
- `buttons_raw  in  WIDTH`: asynchronous pin inputs, active-high.
- `ack  in  1`: synchronous clear of `press_latched` (all bits).
- `pushbuttons  out  WIDTH`: debounced level; connects to `uP.pushbuttons`.
- `press_pulse  out  WIDTH`: one-cycle high on each accepted 0→1 transition.
- `press_latched  out  WIDTH`: sticky record of accepted presses since the last `ack`.

## Operation
- Per bit, a 2-FF synchroniser produces `s1` then `s2`, both resetting to 0.
- Per bit, a counter `cnt` has width clog2(DEBOUNCE_CYCLES) (minimum 1) and resets to 0.
- Per bit, state is the register `stable` (drives `pushbuttons`). Each edge:
  - `s2 == stable`: `cnt <= 0`, no change.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - `s2 != stable` otherwise: `cnt <= cnt+1`.
  - Any single sample equal to `stable` restarts qualification from zero. This is glitch rejection.
- `press_pulse[i]` is a register, loaded on the same edge as the update. It is set to 1 only when the update takes `stable` 0→1; every other edge loads 0. Releases (1→0) produce no pulse.
- `press_latched[i]` behaviour on each edge:
  - Set on the edge where `press_pulse[i]` is loaded with 1.
  - Cleared when `ack` is 1 and no new press is being accepted on bit i.
  - New press and `ack` on the same edge: bit ends at 1 (press wins). Other bits clear normally.
- Bits are fully independent. Simultaneous presses on several bits produce simultaneous pulses and latches.
- Counter never wraps: it is bounded by the update rule at DEBOUNCE_CYCLES-1.

## Timing
- Reset values (asserted low, asynchronous): `s1`, `s2`, `stable`, `cnt`, `press_pulse` and `press_latched` are all 0. `pushbuttons` reads 4'b0000 immediately, without waiting for a clock edge.
- Reset release: the first state change is possible on the first rising edge after `reset` goes high.
- Latency:
  - A clean raw change that is stable before edge E appears on `pushbuttons` and `press_pulse` after edge E+1+DEBOUNCE_CYCLES. That is DEBOUNCE_CYCLES+2 cycles.
  - `press_latched` follows with the same latency.
- Minimum accepted pulse width: DEBOUNCE_CYCLES+1 raw cycles of stable level, given synchroniser alignment. Anything shorter than DEBOUNCE_CYCLES synchronised samples is rejected.
- `press_pulse` width: exactly one cycle per accepted press, regardless of hold time.
- Reset asserted mid-qualification: the count is discarded. After release, qualification restarts from 0 against `stable = 0`.
- `ack` takes effect on the next edge. `press_latched` reads 0 the cycle after.

## Structure
- Shared package/header `nibbler_pkg`:
  - `NIB_WIDTH = 4`.
  - `NIB_DEBOUNCE_SIM = 4`.
  - `NIB_DEBOUNCE_BOARD`: board value for 1 ms at the board clock.
  - The same `NIB_WIDTH` is used by `uP` ports.
- Sub-module `debounce_bit`: one bit's synchroniser, counter, `stable`, pulse and latch, with a `DEBOUNCE_CYCLES` parameter. The top level instantiates `WIDTH` copies in a generate loop and fans `ack` to all of them.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and a 10-unit clock period.
1. **Reset values:** hold `reset` = 0 with `buttons_raw` = 4'b1111 → all outputs 0. Release `reset` → `pushbuttons` = 4'b1111 exactly 6 edges later. `press_pulse` = 4'b1111 for one cycle, then `press_latched` = 4'b1111.
2. **Clean press:** `buttons_raw` 4'b0000→4'b0110 → `pushbuttons` = 4'b0110 after 6 edges. `press_pulse` = 4'b0110 for one cycle only. `press_latched` = 4'b0110 until `ack`. Then 4'b0110→4'b1110 → only bit 3 pulses.
3. **Glitch rejection:** bit 0 high for 3 cycles, low for 1, high for 3, then low → `pushbuttons[0]` never rises and no pulse occurs. Next, bit 0 high for 6 cycles → accepted.
4. **Release:** after an accepted 4'b0110, drop to 4'b0000 → `pushbuttons` = 4'b0000 after 6 edges, with no `press_pulse`. `press_latched` remains 4'b0110.
5. **Ack collision:** `ack` pulsed on the same edge that bit 2's press is accepted, with bit 1 already latched → `press_latched` = 4'b0100. `ack` alone one cycle later → 4'b0000.
6. **Mid-count reset:** `buttons_raw` rises, then `reset` pulses low at edge 4 → outputs 0 immediately. After release, `pushbuttons` rises 6 edges after the release edge.
